// File: rtl/pc_gen_unit_if.sv
// pc_gen_unit_if: fetch-side bundle for the PC generator.
//   Control in : PCSrc, ExtendOut, addr, RegTarget, exc_req, halt, resume, if_ready
//   Status out : if_valid, PC, EPC, exc_taken, src_err
//   slave  modport -> pc_gen_unit
//   master modport -> whoever drives control and consumes the PC
interface pc_gen_unit_if #(
  parameter int ADDR_W = 32
);
  logic [2:0]        PCSrc;
  logic [31:0]       ExtendOut;
  logic [25:0]       addr;
  logic [ADDR_W-1:0] RegTarget;
  logic              exc_req;
  logic              halt;
  logic              resume;
  logic              if_ready;
  logic              if_valid;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] EPC;
  logic              exc_taken;
  logic              src_err;

  modport slave (
    input  PCSrc, ExtendOut, addr, RegTarget, exc_req, halt, resume, if_ready,
    output if_valid, PC, EPC, exc_taken, src_err
  );

  modport master (
    output PCSrc, ExtendOut, addr, RegTarget, exc_req, halt, resume, if_ready,
    input  if_valid, PC, EPC, exc_taken, src_err
  );
endinterface

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: stateful program-counter generator.
//   Owns the PC register, picks the next PC (SEQ / BRANCH / JUMP / JR /
//   exception vector) and offers it to fetch with a valid/ready handshake.
//   Supports stall (if_ready low), halt/resume, misaligned-JR trapping and
//   EPC capture.
// Ports:
//   CLK   : clock, rising edge
//   Reset : asynchronous, active-low reset
//   bus   : pc_gen_unit_if.slave (control in, PC/EPC/status out)
module pc_gen_unit #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0180
) (
  input  logic          CLK,
  input  logic          Reset,
  pc_gen_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

  localparam logic [2:0] SRC_SEQ = 3'd0;
  localparam logic [2:0] SRC_BR  = 3'd1;
  localparam logic [2:0] SRC_J   = 3'd2;
  localparam logic [2:0] SRC_JR  = 3'd3;

  localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VEC);
  // Low 28 bits come from the jump field; anything above is kept from PC+4.
  localparam logic [ADDR_W-1:0] JMP_MASK = ADDR_W'(32'h0FFF_FFFF);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              exc_q, exc_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic              advance;
  logic              jr_misal;

  assign pc4     = pc_q + ADDR_W'(4);
  // Word offset sign-extended and scaled by 4; truncation/extension to
  // ADDR_W gives the mod-2^ADDR_W wrap for free.
  assign br_off  = ADDR_W'({{32{bus.ExtendOut[31]}}, bus.ExtendOut, 2'b00});
  assign br_tgt  = pc4 + br_off;
  assign j_tgt   = (pc4 & ~JMP_MASK) | ADDR_W'({bus.addr, 2'b00});
  assign advance = (state_q == S_RUN) && bus.if_ready;
  assign jr_misal = (bus.RegTarget[1:0] != 2'b00);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_BOOT;
      pc_q    <= RST_PC;
      epc_q   <= '0;
      exc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      exc_q   <= exc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    exc_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_BOOT: state_d = S_RUN;  // exc_req ignored while booting

      S_RUN, S_HALT: begin
        if (bus.exc_req) begin
          // Exception beats halt and any pending advance.
          pc_d    = EXC_PC;
          epc_d   = pc_q;
          exc_d   = 1'b1;
          state_d = S_RUN;
        end else if (advance) begin
          if (bus.halt) state_d = S_HALT;
          unique case (bus.PCSrc)
            SRC_SEQ: pc_d = pc4;
            SRC_BR:  pc_d = br_tgt;
            SRC_J:   pc_d = j_tgt;
            SRC_JR: begin
              if (jr_misal) begin
                pc_d    = EXC_PC;
                epc_d   = pc_q;
                exc_d   = 1'b1;
                state_d = S_RUN;
              end else begin
                pc_d = bus.RegTarget;
              end
            end
            default: err_d = 1'b1;  // reserved encoding: hold PC, flag it
          endcase
        end else if (state_q == S_HALT && bus.resume) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  assign bus.if_valid  = (state_q == S_RUN);
  assign bus.PC        = pc_q;
  assign bus.EPC       = epc_q;
  assign bus.exc_taken = exc_q;
  assign bus.src_err   = err_q;

endmodule
